// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer: default sizing, FSM state
// encoding and the timer width helper.
package pulse_seq_pkg;

    localparam int NUM_CH_DEF = 8;
    localparam int CNT_W_DEF  = 17;
    localparam int MULT_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Width that holds ticks*(mult+1) for the largest ticks and mult.
    function automatic int tmr_w(input int cnt_w, input int mult_w);
        return cnt_w + mult_w + 1;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Prescaled down-counter shared by the DELAY and PULSE phases. On load it
// holds ticks*(mult+1)-1 and counts down; zero marks the final cycle.
module seq_timer
    import pulse_seq_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int MULT_W = MULT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              tick,
    input  logic [CNT_W-1:0]  ticks,
    input  logic [MULT_W-1:0] mult,
    output logic              zero
);

    localparam int TW = tmr_w(CNT_W, MULT_W);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] span;

    assign span = TW'(ticks) * (TW'(mult) + TW'(1));

    // A zero span still occupies one cycle, so it loads as 0 like a span of 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= (span == '0) ? '0 : span - TW'(1);
        end else if (tick && cnt_q != '0) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Walks channels 0..NUM_CH-1 in order, waiting each channel's delay and then
// driving its ex bit for its duration; one shared timer paces both phases.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter  int NUM_CH   = NUM_CH_DEF,
    parameter  int CNT_W    = CNT_W_DEF,
    parameter  int MULT_W   = MULT_W_DEF,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    // One extra code point so an out-of-range index can be presented and rejected.
    localparam int CFG_CH_W = $clog2(NUM_CH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                cfg_we,
    input  logic [CFG_CH_W-1:0] cfg_ch,
    input  logic                cfg_sel,
    input  logic [CNT_W-1:0]    cfg_data,
    input  logic [MULT_W-1:0]   cfg_mult,
    output logic [NUM_CH-1:0]   ex,
    output logic                busy,
    output logic                end_flg,
    output logic                cfg_err
);

    seq_state_t state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;

    logic [NUM_CH-1:0][CNT_W-1:0]  dly_q;
    logic [NUM_CH-1:0][CNT_W-1:0]  dur_q;
    logic [NUM_CH-1:0][MULT_W-1:0] mult_q;

    logic              cfg_hit, cfg_ok;
    logic [CH_W-1:0]   cfg_idx;
    logic              tmr_load, tmr_tick, tmr_zero;
    logic [CNT_W-1:0]  tmr_ticks;
    logic [MULT_W-1:0] tmr_mult;
    logic [NUM_CH-1:0] ex_d;

    assign cfg_hit = (cfg_ch < CFG_CH_W'(NUM_CH));
    assign cfg_ok  = cfg_we && (state_q == ST_IDLE) && cfg_hit;
    assign cfg_idx = cfg_ch[CH_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q  <= '0;
            dur_q  <= '0;
            mult_q <= '0;
        end else if (cfg_ok) begin
            if (cfg_sel) dur_q[cfg_idx] <= cfg_data;
            else         dly_q[cfg_idx] <= cfg_data;
            mult_q[cfg_idx] <= cfg_mult;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_DELAY;
                    ch_d    = '0;
                end
            end
            ST_DELAY: begin
                if (tmr_zero) state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DELAY;
                        ch_d    = ch_q + CH_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            ch_d    = '0;
        end
    end

    // Reload on every phase entry, using the values of the phase being entered.
    assign tmr_load  = (state_d == ST_DELAY || state_d == ST_PULSE) && (state_d != state_q);
    assign tmr_tick  = (state_q == ST_DELAY || state_q == ST_PULSE);
    assign tmr_ticks = (state_d == ST_DELAY) ? dly_q[ch_d] : dur_q[ch_d];
    assign tmr_mult  = mult_q[ch_d];

    seq_timer #(
        .CNT_W  (CNT_W),
        .MULT_W (MULT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .tick  (tmr_tick),
        .ticks (tmr_ticks),
        .mult  (tmr_mult),
        .zero  (tmr_zero)
    );

    // ex is registered from the next state so it lines up exactly with PULSE.
    always_comb begin
        ex_d = '0;
        if (state_d == ST_PULSE && dur_q[ch_d] != '0) ex_d[ch_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            ex      <= '0;
            busy    <= 1'b0;
            end_flg <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            ex      <= ex_d;
            busy    <= (state_d == ST_DELAY) || (state_d == ST_PULSE);
            end_flg <= (state_d == ST_DONE);
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench: each launch pushes the expected pulse/end events, and a
// negedge monitor pops and compares them as the outputs appear.
module tb_pulse_sequencer;

    localparam int NCH = 8;
    localparam int CW  = 17;
    localparam int MW  = 5;
    localparam int NO_CUT = 1 << 30;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           cfg_we = 1'b0;
    logic [3:0]     cfg_ch = '0;
    logic           cfg_sel = 1'b0;
    logic [CW-1:0]  cfg_data = '0;
    logic [MW-1:0]  cfg_mult = '0;
    logic [NCH-1:0] ex;
    logic           busy, end_flg, cfg_err;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int kind;
        int ch;
        int cyc;
        int len;
    } ev_t;

    ev_t q[$];
    int d_m[NCH];
    int p_m[NCH];
    int m_m[NCH];
    int rise_at[NCH];
    logic [NCH-1:0] ex_prev = '0;
    int cut;

    pulse_sequencer #(
        .NUM_CH (NCH),
        .CNT_W  (CW),
        .MULT_W (MW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .cfg_mult (cfg_mult),
        .ex       (ex),
        .busy     (busy),
        .end_flg  (end_flg),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int span(input int t, input int m);
        return (t == 0) ? 1 : t * (m + 1);
    endfunction

    function automatic int pstart(input int t0, input int ch);
        int cur = t0 + 1;
        for (int c = 0; c < ch; c++)
            cur += span(d_m[c], m_m[c]) + span(p_m[c], m_m[c]);
        return cur + span(d_m[ch], m_m[ch]);
    endfunction

    // cut = first cycle in which the sequence is no longer running.
    task automatic push_exp(input int t0, input int cut_c);
        int cur = t0 + 1;
        int ps, len;
        for (int c = 0; c < NCH; c++) begin
            ps = cur + span(d_m[c], m_m[c]);
            if (ps >= cut_c) return;
            if (p_m[c] != 0) begin
                len = p_m[c] * (m_m[c] + 1);
                if (cut_c - ps < len) len = cut_c - ps;
                q.push_back('{0, c, ps, len});
            end
            cur = ps + span(p_m[c], m_m[c]);
        end
        if (cur < cut_c) q.push_back('{1, 0, cur, 0});
    endtask

    task automatic got_ev(input int kind, input int ch, input int c, input int len);
        ev_t e;
        chk("ev_pending", q.size() > 0, 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("ev_kind ch%0d", ch), kind, e.kind);
            chk($sformatf("ev_ch k%0d", kind), ch, e.ch);
            chk($sformatf("ev_cyc k%0d ch%0d", kind, ch), c, e.cyc);
            chk($sformatf("ev_len ch%0d", ch), len, e.len);
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (ex[c] && !ex_prev[c]) rise_at[c] = cyc;
            if (!ex[c] && ex_prev[c]) got_ev(0, c, rise_at[c], cyc - rise_at[c]);
        end
        if (end_flg) got_ev(1, 0, cyc, 0);
        if (ex != '0) chk("onehot", $countones(ex), 1);
        ex_prev = ex;
    end

    task automatic cfg_wr(input int ch, input bit sel, input int data, input int mult);
        bit legal;
        legal = (ch < NCH);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_sel = sel;
        cfg_data = CW'(data); cfg_mult = MW'(mult);
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_err", cfg_err, legal ? 0 : 1);
        if (legal) begin
            if (sel) p_m[ch] = data;
            else     d_m[ch] = data;
            m_m[ch] = mult;
        end else begin
            @(negedge clk);
            chk("cfg_err_fall", cfg_err, 0);
        end
    endtask

    task automatic run_seq(input int cut_ch, input int cut_off, output int cut_c);
        int t0;
        @(negedge clk);
        t0 = cyc;
        cut_c = (cut_ch < 0) ? NO_CUT : pstart(t0, cut_ch) + cut_off;
        push_exp(t0, cut_c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on", busy, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy && !end_flg) break;
        end
        chk("drain", q.size(), 0);
        chk("idle_busy", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            d_m[c] = 0; p_m[c] = 0; m_m[c] = 0; rise_at[c] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ex", ex, 0);
        chk("rst_busy", busy, 0);
        chk("rst_end", end_flg, 0);
        chk("rst_err", cfg_err, 0);
        rst_n = 1'b1;

        // uniform D=2 P=3 M=0
        for (int c = 0; c < NCH; c++) begin
            cfg_wr(c, 1'b0, 2, 0);
            cfg_wr(c, 1'b1, 3, 0);
        end
        run_seq(-1, 0, cut);
        wait_idle();

        // prescaled ch2, zero-duration ch4, plus a rejected write while busy
        cfg_wr(2, 1'b0, 1, 3);
        cfg_wr(2, 1'b1, 2, 3);
        cfg_wr(4, 1'b1, 0, 0);
        run_seq(-1, 0, cut);
        cfg_we = 1'b1; cfg_ch = 4'd0; cfg_sel = 1'b0; cfg_data = CW'(99); cfg_mult = MW'(7);
        @(negedge clk);
        cfg_we = 1'b0;
        chk("busy_cfg_err", cfg_err, 1);
        @(negedge clk);
        chk("busy_cfg_err_fall", cfg_err, 0);
        wait_idle();

        cfg_wr(8, 1'b0, 5, 1);
        run_seq(-1, 0, cut);
        wait_idle();

        // abort in the middle of ch3's pulse
        run_seq(3, 2, cut);
        wait_cyc(cut - 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ex", ex, 0);
        chk("abort_busy", busy, 0);
        wait_idle();
        run_seq(-1, 0, cut);
        wait_idle();

        // reset during ch5 delay
        run_seq(5, -1, cut);
        wait_cyc(cut);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ex", ex, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_end", end_flg, 0);
        chk("mid_rst_err", cfg_err, 0);
        for (int c = 0; c < NCH; c++) begin
            d_m[c] = 0; p_m[c] = 0; m_m[c] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_q", q.size(), 0);
        run_seq(-1, 0, cut);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
